// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one external memory bus between the fetch stage and the
// memory stage. One transaction in flight at a time, data side has priority,
// each result is held until its stage consumes it, and flushed requests still
// finish on the bus but their responses are thrown away.
module bus_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        fetch_request,
    input  logic [31:0] fetch_address,
    input  logic        fetch_accept,
    input  logic        fetch_flush,
    output logic [31:0] fetch_data,
    output logic        fetch_ready,

    input  logic        mem_request,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_write_data,
    input  logic [3:0]  mem_strobe,
    input  logic        mem_accept,
    input  logic        mem_flush,
    output logic [31:0] mem_read_data,
    output logic        mem_ready,

    output logic        ext_valid,
    output logic        ext_instruction,
    output logic [31:0] ext_address,
    output logic [31:0] ext_write_data,
    output logic [3:0]  ext_strobe,
    input  logic        ext_ready,
    input  logic [31:0] ext_read_data
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY_FETCH = 2'd1,
        BUSY_MEM   = 2'd2
    } state_t;

    state_t      state_q;
    logic        f_hold_q;
    logic        m_hold_q;
    logic        f_discard_q;
    logic        m_discard_q;
    logic [31:0] fetch_data_q;
    logic [31:0] mem_read_data_q;
    logic        ext_valid_q;
    logic        ext_instruction_q;
    logic [31:0] ext_address_q;
    logic [31:0] ext_write_data_q;
    logic [3:0]  ext_strobe_q;

    logic        fetch_pending;
    logic        mem_pending;

    // A side may issue only with no held result, no flush this cycle and no
    // transaction of its own still on the bus (live or being discarded).
    always_comb begin
        fetch_pending = fetch_request && !f_hold_q && !fetch_flush &&
                        (state_q != BUSY_FETCH) && !f_discard_q;
        mem_pending   = mem_request && !m_hold_q && !mem_flush &&
                        (state_q != BUSY_MEM) && !m_discard_q;
    end

    // Bus FSM with registered bus outputs and per-side hold/discard tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            f_hold_q          <= 1'b0;
            m_hold_q          <= 1'b0;
            f_discard_q       <= 1'b0;
            m_discard_q       <= 1'b0;
            fetch_data_q      <= 32'd0;
            mem_read_data_q   <= 32'd0;
            ext_valid_q       <= 1'b0;
            ext_instruction_q <= 1'b0;
            ext_address_q     <= 32'd0;
            ext_write_data_q  <= 32'd0;
            ext_strobe_q      <= 4'd0;
        end else begin
            // Consuming or flushing a held result frees that side; a
            // completion below may set the flag again (later write wins).
            if (fetch_accept || fetch_flush) begin
                f_hold_q <= 1'b0;
            end
            if (mem_accept || mem_flush) begin
                m_hold_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (mem_pending) begin
                        ext_valid_q       <= 1'b1;
                        ext_instruction_q <= 1'b0;
                        ext_address_q     <= mem_address;
                        ext_write_data_q  <= mem_write_data;
                        ext_strobe_q      <= mem_strobe;
                        state_q           <= BUSY_MEM;
                    end else if (fetch_pending) begin
                        // Write data is a don't-care on reads; left as is.
                        ext_valid_q       <= 1'b1;
                        ext_instruction_q <= 1'b1;
                        ext_address_q     <= fetch_address;
                        ext_strobe_q      <= 4'd0;
                        state_q           <= BUSY_FETCH;
                    end
                end

                BUSY_FETCH: begin
                    if (ext_ready) begin
                        fetch_data_q <= ext_read_data;
                        // A flush arriving with the response drops it too.
                        if (f_discard_q || fetch_flush) begin
                            f_discard_q <= 1'b0;
                        end else begin
                            f_hold_q <= 1'b1;
                        end
                        ext_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (fetch_flush) begin
                        f_discard_q <= 1'b1;
                    end
                end

                BUSY_MEM: begin
                    if (ext_ready) begin
                        mem_read_data_q <= ext_read_data;
                        // A flushed store has already reached memory; only
                        // the completion indication is suppressed.
                        if (m_discard_q || mem_flush) begin
                            m_discard_q <= 1'b0;
                        end else begin
                            m_hold_q <= 1'b1;
                        end
                        ext_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (mem_flush) begin
                        m_discard_q <= 1'b1;
                    end
                end

                default: begin
                    ext_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign fetch_data      = fetch_data_q;
    assign fetch_ready     = f_hold_q;
    assign mem_read_data   = mem_read_data_q;
    assign mem_ready       = m_hold_q;
    assign ext_valid       = ext_valid_q;
    assign ext_instruction = ext_instruction_q;
    assign ext_address     = ext_address_q;
    assign ext_write_data  = ext_write_data_q;
    assign ext_strobe      = ext_strobe_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios followed by randomized traffic, all
// checked cycle by cycle against a transaction-level model of the arbiter.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_request;
    logic [31:0] fetch_address;
    logic        fetch_accept;
    logic        fetch_flush;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic        mem_request;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_strobe;
    logic        mem_accept;
    logic        mem_flush;
    logic [31:0] mem_read_data;
    logic        mem_ready;
    logic        ext_valid;
    logic        ext_instruction;
    logic [31:0] ext_address;
    logic [31:0] ext_write_data;
    logic [3:0]  ext_strobe;
    logic        ext_ready;
    logic [31:0] ext_read_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the transaction on the bus (owner 0 = none, 1 = fetch, 2 = data)
    // and whether its response is to be thrown away, plus each side's result.
    int          md_owner;
    logic [31:0] md_addr;
    logic [31:0] md_wdata;
    logic [3:0]  md_strb;
    bit          md_drop;
    bit          md_f_rdy;
    bit          md_m_rdy;
    logic [31:0] md_f_data;
    logic [31:0] md_m_data;

    bus_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_request  (fetch_request),
        .fetch_address  (fetch_address),
        .fetch_accept   (fetch_accept),
        .fetch_flush    (fetch_flush),
        .fetch_data     (fetch_data),
        .fetch_ready    (fetch_ready),
        .mem_request    (mem_request),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_strobe     (mem_strobe),
        .mem_accept     (mem_accept),
        .mem_flush      (mem_flush),
        .mem_read_data  (mem_read_data),
        .mem_ready      (mem_ready),
        .ext_valid      (ext_valid),
        .ext_instruction(ext_instruction),
        .ext_address    (ext_address),
        .ext_write_data (ext_write_data),
        .ext_strobe     (ext_strobe),
        .ext_ready      (ext_ready),
        .ext_read_data  (ext_read_data)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b, want %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs as seen at the edge.
    task automatic model_step();
        bit nf;
        bit nm;
        bit own_flush;
        if (reset) begin
            md_owner  = 0;
            md_addr   = 32'd0;
            md_wdata  = 32'd0;
            md_strb   = 4'd0;
            md_drop   = 1'b0;
            md_f_rdy  = 1'b0;
            md_m_rdy  = 1'b0;
            md_f_data = 32'd0;
            md_m_data = 32'd0;
        end else begin
            nf = md_f_rdy && !(fetch_accept || fetch_flush);
            nm = md_m_rdy && !(mem_accept || mem_flush);
            if (md_owner == 0) begin
                if (mem_request && !md_m_rdy && !mem_flush) begin
                    md_owner = 2;
                    md_addr  = mem_address;
                    md_wdata = mem_write_data;
                    md_strb  = mem_strobe;
                    md_drop  = 1'b0;
                end else if (fetch_request && !md_f_rdy && !fetch_flush) begin
                    md_owner = 1;
                    md_addr  = fetch_address;
                    md_strb  = 4'd0;
                    md_drop  = 1'b0;
                end
            end else begin
                own_flush = (md_owner == 1) ? fetch_flush : mem_flush;
                if (ext_ready) begin
                    if (md_owner == 1) begin
                        md_f_data = ext_read_data;
                        if (!md_drop && !own_flush) nf = 1'b1;
                    end else begin
                        md_m_data = ext_read_data;
                        if (!md_drop && !own_flush) nm = 1'b1;
                    end
                    md_owner = 0;
                    md_drop  = 1'b0;
                end else if (own_flush) begin
                    md_drop = 1'b1;
                end
            end
            md_f_rdy = nf;
            md_m_rdy = nm;
        end
    endtask

    task automatic check_model();
        chk1("ext_valid", ext_valid, md_owner != 0);
        if (md_owner != 0) begin
            chk1("ext_instruction", ext_instruction, md_owner == 1);
            chk32("ext_address", ext_address, md_addr);
            chk32("ext_strobe", {28'd0, ext_strobe}, {28'd0, md_strb});
            if (md_owner == 2) chk32("ext_write_data", ext_write_data, md_wdata);
        end
        chk1("fetch_ready", fetch_ready, md_f_rdy);
        chk1("mem_ready", mem_ready, md_m_rdy);
        chk32("fetch_data", fetch_data, md_f_data);
        chk32("mem_read_data", mem_read_data, md_m_data);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        fetch_request  = 1'b0;
        fetch_address  = 32'd0;
        fetch_accept   = 1'b0;
        fetch_flush    = 1'b0;
        mem_request    = 1'b0;
        mem_address    = 32'd0;
        mem_write_data = 32'd0;
        mem_strobe     = 4'd0;
        mem_accept     = 1'b0;
        mem_flush      = 1'b0;
        ext_ready      = 1'b0;
        ext_read_data  = 32'd0;
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        chk1("rst ext_valid", ext_valid, 1'b0);
        chk1("rst ext_instruction", ext_instruction, 1'b0);
        chk1("rst fetch_ready", fetch_ready, 1'b0);
        chk1("rst mem_ready", mem_ready, 1'b0);
        chk32("rst ext_address", ext_address, 32'd0);
        chk32("rst ext_write_data", ext_write_data, 32'd0);
        chk32("rst ext_strobe", {28'd0, ext_strobe}, 32'd0);
        chk32("rst fetch_data", fetch_data, 32'd0);
        chk32("rst mem_read_data", mem_read_data, 32'd0);
        reset = 1'b0;
        tick();

        // Single fetch
        fetch_request = 1'b1;
        fetch_address = 32'h100;
        ext_ready     = 1'b1;
        ext_read_data = 32'h13;
        tick();
        chk1("sf valid c1", ext_valid, 1'b1);
        chk32("sf addr c1", ext_address, 32'h100);
        chk1("sf instr c1", ext_instruction, 1'b1);
        chk32("sf strobe c1", {28'd0, ext_strobe}, 32'd0);
        fetch_request = 1'b0;
        tick();
        chk1("sf ready c2", fetch_ready, 1'b1);
        chk32("sf data c2", fetch_data, 32'h13);
        ext_ready = 1'b0;
        tick();
        tick();
        chk1("sf ready held", fetch_ready, 1'b1);
        fetch_accept = 1'b1;
        tick();
        chk1("sf ready after accept", fetch_ready, 1'b0);
        idle_inputs();
        tick();

        // Simultaneous fetch and load: data first
        fetch_request = 1'b1;
        fetch_address = 32'h200;
        mem_request   = 1'b1;
        mem_address   = 32'h8000;
        mem_strobe    = 4'd0;
        ext_ready     = 1'b1;
        ext_read_data = 32'hDEAD0001;
        tick();
        chk32("sim first addr", ext_address, 32'h8000);
        chk1("sim first is data", ext_instruction, 1'b0);
        tick();
        chk1("sim mem_ready", mem_ready, 1'b1);
        chk32("sim load data", mem_read_data, 32'hDEAD0001);
        chk1("sim bus idle gap", ext_valid, 1'b0);
        ext_read_data = 32'h93;
        tick();
        chk1("sim fetch valid", ext_valid, 1'b1);
        chk32("sim fetch addr", ext_address, 32'h200);
        chk1("sim fetch instr", ext_instruction, 1'b1);
        mem_accept  = 1'b1;
        mem_request = 1'b0;
        tick();
        chk1("sim fetch_ready", fetch_ready, 1'b1);
        chk32("sim fetch data", fetch_data, 32'h93);
        chk1("sim mem_ready cleared", mem_ready, 1'b0);
        fetch_accept  = 1'b1;
        fetch_request = 1'b0;
        mem_accept    = 1'b0;
        tick();
        idle_inputs();
        tick();

        // Store with three wait states
        mem_request    = 1'b1;
        mem_address    = 32'h40;
        mem_write_data = 32'hAABB;
        mem_strobe     = 4'b0011;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("st valid wait", ext_valid, 1'b1);
            chk32("st addr wait", ext_address, 32'h40);
            chk32("st wdata wait", ext_write_data, 32'hAABB);
            chk32("st strobe wait", {28'd0, ext_strobe}, 32'h3);
            chk1("st no ready yet", mem_ready, 1'b0);
        end
        ext_ready = 1'b1;
        tick();
        chk1("st mem_ready", mem_ready, 1'b1);
        mem_accept  = 1'b1;
        mem_request = 1'b0;
        ext_ready   = 1'b0;
        tick();
        idle_inputs();
        tick();

        // Flushed fetch, then a normal fetch
        fetch_request = 1'b1;
        fetch_address = 32'h280;
        tick();
        fetch_request = 1'b0;
        fetch_flush   = 1'b1;
        tick();
        fetch_flush   = 1'b0;
        ext_ready     = 1'b1;
        ext_read_data = 32'hBAD;
        tick();
        chk1("fl dropped", fetch_ready, 1'b0);
        fetch_request = 1'b1;
        fetch_address = 32'h300;
        ext_read_data = 32'h33;
        tick();
        chk32("fl next addr", ext_address, 32'h300);
        fetch_request = 1'b0;
        tick();
        chk1("fl next ready", fetch_ready, 1'b1);
        chk32("fl next data", fetch_data, 32'h33);
        fetch_accept = 1'b1;
        tick();
        idle_inputs();
        tick();

        // Held response with a stalled memory stage
        mem_request   = 1'b1;
        mem_address   = 32'h9000;
        ext_ready     = 1'b1;
        ext_read_data = 32'h1234;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("hold mem_ready", mem_ready, 1'b1);
            chk1("hold no reissue", ext_valid, 1'b0);
        end
        mem_accept  = 1'b1;
        mem_request = 1'b0;
        tick();
        chk1("hold released", mem_ready, 1'b0);
        idle_inputs();
        tick();

        // Reset in the middle of a data access
        mem_request    = 1'b1;
        mem_address    = 32'h44;
        mem_write_data = 32'h55;
        mem_strobe     = 4'hF;
        tick();
        mem_request = 1'b0;
        reset       = 1'b1;
        tick();
        chk1("mrst ext_valid", ext_valid, 1'b0);
        chk32("mrst ext_address", ext_address, 32'd0);
        chk32("mrst ext_strobe", {28'd0, ext_strobe}, 32'd0);
        reset     = 1'b0;
        ext_ready = 1'b1;
        tick();
        tick();
        chk1("mrst no mem_ready", mem_ready, 1'b0);
        idle_inputs();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            reset          = ($urandom_range(0, 199) == 0);
            fetch_request  = ($urandom_range(0, 9) < 6);
            fetch_address  = $urandom & 32'hFFFF_FFFC;
            fetch_accept   = ($urandom_range(0, 9) < 5);
            fetch_flush    = ($urandom_range(0, 9) == 0);
            mem_request    = ($urandom_range(0, 9) < 4);
            mem_address    = $urandom;
            mem_write_data = $urandom;
            mem_strobe     = 4'($urandom);
            mem_accept     = ($urandom_range(0, 9) < 5);
            mem_flush      = ($urandom_range(0, 19) == 0);
            ext_ready      = ($urandom_range(0, 9) < 5);
            ext_read_data  = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Single-master arbiter between the fetch stage and the memory stage for the one external memory bus. Issues one bus transaction at a time, holds each result until the requesting stage consumes it, and produces the `fetch_ready` / `mem_ready` indications consumed by the hazard unit. Data accesses have priority over instruction fetches. Flushed requests are completed on the bus and their results discarded.

## Interface
- No parameters; address and data are fixed at 32 bits.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `fetch_request` in 1: fetch stage wants the instruction at `fetch_address`.
- `fetch_address` in 32: instruction address, word aligned.
- `fetch_accept` in 1: fetch stage consumes the held instruction this cycle (driven by `!stall_fetch`).
- `fetch_flush` in 1: discard any pending, held or in-flight fetch (branch or trap redirect).
- `fetch_data` out 32: held instruction word.
- `fetch_ready` out 1: `fetch_data` is valid.
- `mem_request` in 1: memory stage has a load or store (the `load_store` signal).
- `mem_address` in 32: data address.
- `mem_write_data` in 32: store data, already lane-aligned.
- `mem_strobe` in 4: byte-lane write enables; `0` means load.
- `mem_accept` in 1: memory stage advances this cycle (driven by `!stall_memory`).
- `mem_flush` in 1: discard the held or in-flight data response (trap).
- `mem_read_data` out 32: held load data.
- `mem_ready` out 1: data access is complete.
- `ext_valid` out 1: bus request valid.
- `ext_instruction` out 1: current request is a fetch.
- `ext_address` out 32: bus address.
- `ext_write_data` out 32: bus write data.
- `ext_strobe` out 4: bus byte enables; `0` means read.
- `ext_ready` in 1: slave completes the transfer this cycle.
- `ext_read_data` in 32: read data, valid while `ext_valid && ext_ready`.

## Operation
- The bus FSM has three states: `IDLE`, `BUSY_FETCH`, `BUSY_MEM`.
- Per-side state: hold flags `f_hold` and `m_hold`, result buffers, and discard flags `f_discard` and `m_discard`.
- A fetch is pending when `fetch_request && !f_hold && !fetch_flush`, the bus is not in `BUSY_FETCH`, and `f_discard` is clear.
- A data access is pending when `mem_request && !m_hold && !mem_flush`, the bus is not in `BUSY_MEM`, and `m_discard` is clear.
- In `IDLE`:
  - If a data access is pending, latch `mem_address`, `mem_write_data` and `mem_strobe`, then go to `BUSY_MEM`.
  - Otherwise, if a fetch is pending, latch `fetch_address` with strobe `0`, then go to `BUSY_FETCH`.
  - Data wins any tie.
- In `BUSY_*`, when `ext_ready` is high:
  - Capture `ext_read_data` into that side's buffer.
  - Set that side's hold flag, unless its discard flag is set; in that case clear the discard flag instead.
  - Return to `IDLE`.
- `ext_valid = (state != IDLE)`. All `ext_*` outputs come from registers and stay stable until `ext_ready`.
- `fetch_ready = f_hold` and `mem_ready = m_hold`. Buffers hold their values until the next capture.
- `fetch_accept` while `f_hold` is set clears `f_hold`. `mem_accept` while `m_hold` is set clears `m_hold`.
- `fetch_flush`:
  - Clears `f_hold`.
  - In `BUSY_FETCH`, sets `f_discard`. If `ext_ready` is high in the same cycle, the completing response is dropped instead.
  - Blocks fetch issue in that cycle.
- `mem_flush` does the same for the data side. A flushed store still completes on the bus; memory side effects are not undone.
- A new request on a side is sampled only in a cycle that starts with that side's hold flag clear. Accepting and reissuing in the same cycle is not supported.

## Timing
- Reset values:
  - State is `IDLE`.
  - `ext_valid`, `ext_instruction`, `fetch_ready` and `mem_ready` are 0.
  - `ext_address`, `ext_write_data`, `ext_strobe`, `fetch_data` and `mem_read_data` are 0.
  - Hold and discard flags are cleared.
- Reset mid-transaction drops `ext_valid` on the next edge. The slave is reset with the core.
- Latency, with the request first seen in cycle 0 and the bus idle:
  - `ext_valid` rises in cycle 1.
  - With `ext_ready=1` in cycle 1, `*_ready` rises in cycle 2.
  - Each wait state on `ext_ready` adds one cycle.
- Fetch throughput is at best one instruction per 3 cycles.
- A fetch arriving while `BUSY_MEM` issues in the cycle after the data access completes. The reverse case (data waiting on a fetch) works the same way.
- `*_accept` and `*_flush` in the same cycle clear the hold flag either way. `ext_ready` and a flush in the same cycle drop the response.

## Test plan
- **Single fetch:** `fetch_request`, address `0x100`, `ext_ready=1`, read data `0x00000013`. Expect `ext_valid` in cycle 1 with address `0x100`, `ext_instruction=1`, strobe `0`; `fetch_ready=1`, `fetch_data=0x13` in cycle 2, held until `fetch_accept`.
- **Simultaneous requests:** fetch `0x200` and load `0x8000` arrive together. Expect the bus to issue `0x8000` first; the fetch issues the cycle after the load completes.
- **Store with wait states:** `mem_strobe=4'b0011`, data `0xAABB`, `ext_ready` low for 3 cycles. Expect `ext_*` stable across the wait; `mem_ready` rises exactly one cycle after `ext_ready`.
- **Flushed fetch:** `fetch_flush` while `BUSY_FETCH`. Expect completion to leave `fetch_ready=0`; the next request to `0x300` issues normally and returns its own data.
- **Held response:** `mem_accept=0` for 4 cycles after completion. Expect `mem_ready` to stay 1 with no bus reissue; `mem_ready` drops the cycle after `mem_accept=1`.
- **Reset mid-transaction:** `reset` during `BUSY_MEM`. Expect all outputs 0 the next cycle and no `mem_ready` afterwards.
